// File: rtl/x_srl_pkg.sv
`default_nettype none
// ============================================================================
// Package : x_srl_pkg
// Brief   : Sizing helpers shared by the x_srl_chain addressable shift register
// Revision: 1.0
// ============================================================================
package x_srl_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // FILL must represent DEPTH itself, hence one bit beyond the address width
  function automatic int fill_width(input int aw);
    return aw + 1;
  endfunction

  function automatic int init_lsb(input int width, input int idx);
    return width * idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/x_srl_fill_ctr.sv
`default_nettype none
// ============================================================================
// Module  : x_srl_fill_ctr
// Brief   : Saturating fill counter and addressed-entry valid compare
// Revision: 1.0
// ============================================================================
module x_srl_fill_ctr #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int FW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_ce,
  input  logic          i_clr,
  input  logic [AW-1:0] i_addr,
  output logic [FW-1:0] o_fill,
  output logic          o_vld
);

  localparam logic [FW-1:0] c_depth = FW'(DEPTH);

  logic [FW-1:0] r_fill;

  // A clear coinciding with a shift still counts the entry written on that edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill <= '0;
    end else if (i_clr) begin
      r_fill <= i_ce ? FW'(1) : '0;
    end else if (i_ce && (r_fill != c_depth)) begin
      r_fill <= r_fill + FW'(1);
    end
  end

  assign o_fill = r_fill;
  assign o_vld  = r_fill > {1'b0, i_addr};

endmodule
`default_nettype wire

// File: rtl/x_srl_chain.sv
`default_nettype none
// ============================================================================
// Module  : x_srl_chain
// Brief   : WIDTH x DEPTH addressable shift register with cascade tap,
//           registered read port and fill tracking
// Revision: 1.0
// ============================================================================
module x_srl_chain
  import x_srl_pkg::*;
#(
  parameter int                     WIDTH = 1,
  parameter int                     DEPTH = 16,
  parameter logic [WIDTH*DEPTH-1:0] INIT  = '0,
  localparam int                    AW    = clog2(DEPTH),
  localparam int                    FW    = fill_width(AW)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CE,
  input  logic             CLR,
  input  logic [WIDTH-1:0] D,
  input  logic [AW-1:0]    A,
  input  logic             OCE,
  output logic [WIDTH-1:0] Q,
  output logic             Q_VLD,
  output logic [WIDTH-1:0] QR,
  output logic             QR_VLD,
  output logic [WIDTH-1:0] Q_LAST,
  output logic [FW-1:0]    FILL
);

  logic [WIDTH-1:0] r_data [DEPTH];
  logic [WIDTH-1:0] r_qr;
  logic             r_qr_vld;
  logic             w_q_vld;
  logic [FW-1:0]    w_fill;

  // Reset reloads INIT asynchronously so the read mux shows it immediately
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= INIT[init_lsb(WIDTH, i) +: WIDTH];
      end
    end else if (CE) begin
      r_data[0] <= D;
      for (int i = 1; i < DEPTH; i++) begin
        r_data[i] <= r_data[i-1];
      end
    end
  end

  x_srl_fill_ctr #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .FW    (FW)
  ) u_fill (
    .clk    (CLK),
    .rst_n  (RST_N),
    .i_ce   (CE),
    .i_clr  (CLR),
    .i_addr (A),
    .o_fill (w_fill),
    .o_vld  (w_q_vld)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_qr     <= '0;
      r_qr_vld <= 1'b0;
    end else if (OCE) begin
      r_qr     <= r_data[A];
      r_qr_vld <= w_q_vld;
    end
  end

  assign Q      = r_data[A];
  assign Q_VLD  = w_q_vld;
  assign QR     = r_qr;
  assign QR_VLD = r_qr_vld;
  assign Q_LAST = r_data[DEPTH-1];
  assign FILL   = w_fill;

endmodule
`default_nettype wire

// File: tb/tb_x_srl_chain.sv
`default_nettype none
// ============================================================================
// Module  : tb_x_srl_chain
// Brief   : Self-checking bench for x_srl_chain (WIDTH=8, DEPTH=16, INIT[i]=i)
// Revision: 1.0
// ============================================================================
module tb_x_srl_chain;

  localparam int N = 16;

  logic       CLK = 1'b0;
  logic       RST_N, CE, CLR, OCE;
  logic [7:0] D;
  logic [3:0] A;
  logic [7:0] Q, QR, Q_LAST;
  logic       Q_VLD, QR_VLD;
  logic [4:0] FILL;

  int vectors = 0;
  int errors  = 0;

  int m_data[N];
  int m_fill, m_qr, m_qv;

  typedef struct {
    logic [7:0] d;
    logic [3:0] a;
    logic [7:0] q;
    logic       vld;
    logic [4:0] fill;
  } vec_t;

  vec_t tbl[16];

  x_srl_chain #(
    .WIDTH (8),
    .DEPTH (16),
    .INIT  (128'h0F0E0D0C0B0A09080706050403020100)
  ) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .CE     (CE),
    .CLR    (CLR),
    .D      (D),
    .A      (A),
    .OCE    (OCE),
    .Q      (Q),
    .Q_VLD  (Q_VLD),
    .QR     (QR),
    .QR_VLD (QR_VLD),
    .Q_LAST (Q_LAST),
    .FILL   (FILL)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_data[i] = i;
    m_fill = 0;
    m_qr   = 0;
    m_qv   = 0;
  endtask

  // Behavioural view: a list of entries, newest first, plus a counter of valid ones
  task automatic model_edge();
    int q, qv;
    q  = m_data[A];
    qv = (m_fill > int'(A)) ? 1 : 0;
    if (OCE) begin
      m_qr = q;
      m_qv = qv;
    end
    if (CE) begin
      for (int i = N - 1; i > 0; i--) m_data[i] = m_data[i-1];
      m_data[0] = int'(D);
    end
    if (CLR) m_fill = CE ? 1 : 0;
    else if (CE && m_fill < N) m_fill = m_fill + 1;
  endtask

  task automatic step();
    model_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".q"},      32'(Q),      m_data[A]);
    chk({tag, ".q_vld"},  32'(Q_VLD),  (m_fill > int'(A)) ? 1 : 0);
    chk({tag, ".q_last"}, 32'(Q_LAST), m_data[N-1]);
    chk({tag, ".fill"},   32'(FILL),   m_fill);
    chk({tag, ".qr"},     32'(QR),     m_qr);
    chk({tag, ".qr_vld"}, 32'(QR_VLD), m_qv);
  endtask

  initial begin
    int exp_qr, exp_qv;

    // {d, a, expected q at a after the edge, expected q_vld, expected fill}
    tbl[0]  = '{8'h10, 4'd0,  8'h10, 1'b1, 5'd1};
    tbl[1]  = '{8'h11, 4'd1,  8'h10, 1'b1, 5'd2};
    tbl[2]  = '{8'h12, 4'd2,  8'h10, 1'b1, 5'd3};
    tbl[3]  = '{8'h13, 4'd4,  8'h00, 1'b0, 5'd4};
    tbl[4]  = '{8'h14, 4'd0,  8'h14, 1'b1, 5'd5};
    tbl[5]  = '{8'h15, 4'd5,  8'h10, 1'b1, 5'd6};
    tbl[6]  = '{8'h16, 4'd7,  8'h00, 1'b0, 5'd7};
    tbl[7]  = '{8'h17, 4'd15, 8'h07, 1'b0, 5'd8};
    tbl[8]  = '{8'h18, 4'd4,  8'h14, 1'b1, 5'd9};
    tbl[9]  = '{8'h19, 4'd12, 8'h02, 1'b0, 5'd10};
    tbl[10] = '{8'h1A, 4'd10, 8'h10, 1'b1, 5'd11};
    tbl[11] = '{8'h1B, 4'd11, 8'h10, 1'b1, 5'd12};
    tbl[12] = '{8'h1C, 4'd13, 8'h00, 1'b0, 5'd13};
    tbl[13] = '{8'h1D, 4'd1,  8'h1C, 1'b1, 5'd14};
    tbl[14] = '{8'h1E, 4'd14, 8'h10, 1'b1, 5'd15};
    tbl[15] = '{8'h1F, 4'd15, 8'h10, 1'b1, 5'd16};

    RST_N = 1'b0; CE = 1'b0; CLR = 1'b0; OCE = 1'b0; D = '0; A = 4'd5;
    #12;
    model_reset();
    chk("rst.q_a5",   32'(Q),      32'h05);
    chk("rst.q_vld",  32'(Q_VLD),  0);
    chk("rst.fill",   32'(FILL),   0);
    chk("rst.qr",     32'(QR),     0);
    chk("rst.q_last", 32'(Q_LAST), 32'h0F);
    A = 4'd9;
    #1;
    chk("rst.q_a9", 32'(Q), 32'h09);
    @(negedge CLK);
    RST_N = 1'b1;
    step();
    check_all("idle");

    // Shift and latency
    for (int k = 0; k < 16; k++) begin
      CE = 1'b1; D = tbl[k].d; A = tbl[k].a;
      step();
      chk($sformatf("tbl%0d.q", k),     32'(Q),     32'(tbl[k].q));
      chk($sformatf("tbl%0d.q_vld", k), 32'(Q_VLD), 32'(tbl[k].vld));
      chk($sformatf("tbl%0d.fill", k),  32'(FILL),  32'(tbl[k].fill));
      if (k == 2) begin
        A = 4'd3;
        #1;
        chk("edge3.q_vld_a3", 32'(Q_VLD), 0);
      end
      check_all($sformatf("tbl%0d", k));
    end
    A = 4'd0;  #1; chk("full.q_a0",  32'(Q), 32'h1F);
    A = 4'd15; #1; chk("full.q_a15", 32'(Q), 32'h10);
    chk("full.q_last", 32'(Q_LAST), 32'h10);
    chk("full.fill",   32'(FILL),   16);
    D = 8'h20;
    step();
    chk("sat.fill",   32'(FILL),   16);
    chk("sat.q_last", 32'(Q_LAST), 32'h11);

    // CE hold with D toggling
    CE = 1'b0;
    for (int k = 0; k < 5; k++) begin
      D = ~D; A = 4'(k * 3);
      step();
      check_all($sformatf("hold%0d", k));
    end
    chk("hold.q_last", 32'(Q_LAST), 32'h11);

    // CLR with and without CE
    CLR = 1'b1; CE = 1'b1; D = 8'hAA;
    step();
    CLR = 1'b0; A = 4'd0;
    #1;
    chk("clr_ce.q_a0", 32'(Q),    32'hAA);
    chk("clr_ce.fill", 32'(FILL), 1);
    for (int k = 0; k < 9; k++) begin
      D = 8'($urandom);
      step();
    end
    chk("fill10", 32'(FILL), 10);
    CLR = 1'b1; CE = 1'b0;
    step();
    CLR = 1'b0;
    chk("clr.fill", 32'(FILL), 0);
    for (int a = 0; a < N; a++) begin
      A = 4'(a);
      #0.5;
      chk($sformatf("clr.q_vld_a%0d", a), 32'(Q_VLD), 0);
    end
    check_all("clr");

    // Output register
    A = 4'd4; OCE = 1'b1; CE = 1'b1; D = 8'h3C;
    exp_qr = m_data[4];
    exp_qv = (m_fill > 4) ? 1 : 0;
    step();
    chk("oce.qr",     32'(QR),     exp_qr);
    chk("oce.qr_vld", 32'(QR_VLD), exp_qv);
    OCE = 1'b0;
    for (int k = 0; k < 3; k++) begin
      D = 8'($urandom);
      step();
      chk($sformatf("oce_hold%0d.qr", k), 32'(QR), exp_qr);
      check_all($sformatf("oce_hold%0d", k));
    end

    // Randomised traffic against the model
    for (int k = 0; k < 300; k++) begin
      CE  = ($urandom_range(3) != 0);
      CLR = ($urandom_range(15) == 0);
      OCE = $urandom_range(1) == 1;
      D   = 8'($urandom);
      A   = 4'($urandom_range(15));
      step();
      check_all($sformatf("rnd%0d", k));
    end

    // Asynchronous reset in the middle of a CE burst
    CLR = 1'b0; CE = 1'b1; OCE = 1'b1;
    for (int k = 0; k < 3; k++) begin
      D = 8'h60 + 8'(k);
      step();
    end
    #2;
    RST_N = 1'b0;
    model_reset();
    A = 4'd3;
    #1;
    chk("mid_rst.q_a3",   32'(Q),      32'h03);
    chk("mid_rst.fill",   32'(FILL),   0);
    chk("mid_rst.qr",     32'(QR),     0);
    chk("mid_rst.qr_vld", 32'(QR_VLD), 0);
    chk("mid_rst.q_last", 32'(Q_LAST), 32'h0F);
    check_all("mid_rst");
    #3;
    RST_N = 1'b1;
    OCE = 1'b0; D = 8'h5A;
    step();
    A = 4'd0; #1;
    chk("post_rst.q_a0", 32'(Q),    32'h5A);
    chk("post_rst.fill", 32'(FILL), 1);
    A = 4'd1; #1;
    chk("post_rst.q_a1", 32'(Q),    32'h00);
    check_all("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/x_srl_chain.md
# x_srl_chain

Parametrised addressable shift register: successor to the 16-deep, 1-bit SRL primitive, generalised to WIDTH-bit lanes and power-of-two DEPTH. Adds an asynchronous active-low reset, a cascade tap, an optional registered read port and fill tracking that flags whether the addressed entry holds data shifted in since reset or clear. Used as a delay line / tap buffer in the simprims-style library and as a cascadable building block for longer chains.

## Interface
- WIDTH, 1, data bits per entry (1..64)
- DEPTH, 16, entries; power of two, 2..256
- INIT, all-zero, WIDTH*DEPTH bits; entry i resets to INIT[i*WIDTH +: WIDTH]
- AW, clog2(DEPTH), address width (derived, not overridable)

Ports:
- CLK  in  1  clock; all state on rising edge
- RST_N  in  1  reset; asynchronous, active-low
- CE  in  1  shift enable
- CLR  in  1  synchronous fill clear; data untouched
- D  in  WIDTH  shift-in data
- A  in  AW  read address; 0 = newest entry
- OCE  in  1  output register enable
- Q  out  WIDTH  combinational read, data[A]
- Q_VLD  out  1  combinational, FILL > A
- QR  out  WIDTH  registered Q
- QR_VLD  out  1  registered Q_VLD
- Q_LAST  out  WIDTH  data[DEPTH-1], the cascade output
- FILL  out  AW+1  saturating count of entries written since reset or clear

## Operation
- Shift: CE=1 at an edge gives data[0]<=D and data[i]<=data[i-1] for i=1..DEPTH-1. CE=0 holds all entries.
- Q = data[A] and Q_VLD follow A, data and FILL combinationally, with no clock latency.
- FILL:
  - Increments on each CE edge and saturates at DEPTH.
  - CLR=1, CE=0 sets FILL to 0.
  - CLR=1, CE=1 sets FILL to 1, because the shift still occurs and the new entry is valid.
- Output register:
  - OCE=1 at an edge loads QR<=Q and QR_VLD<=Q_VLD, both sampled before that edge's shift.
  - OCE=0 holds QR and QR_VLD.
- Reset (RST_N=0, at any time, including mid-shift):
  - data loads INIT immediately.
  - FILL=0, QR=0, QR_VLD=0.
  - Q = INIT entry A, Q_VLD=0, Q_LAST = INIT entry DEPTH-1.
- Release: the first rising edge with RST_N=1 operates normally. No synchroniser is inside; the caller supplies a synchronously deasserted RST_N.
- Cascade: Q_LAST of one instance drives D of the next, with shared CE.
- Arithmetic: FILL is unsigned AW+1 bits. The comparison FILL > A zero-extends A. A never wraps because its range equals DEPTH.

## Timing
- Q, Q_VLD: 0-cycle combinational read of current state. A change on A is visible in the same cycle.
- Data written at edge k with CE=1 sits at address n after n further CE edges. It is visible on Q, with A=n, after edge k+n.
- QR, QR_VLD: 1 cycle after Q and Q_VLD when OCE=1.
- FILL updates on the same edge as the shift.
- Once saturated, FILL stays at DEPTH under CE. Q_VLD is then 1 for all A.

## Structure
- Package x_srl_pkg holds:
  - a clog2 function;
  - the FILL width rule (AW+1);
  - a localparam helper for extracting INIT slices.
- Sub-module x_srl_fill_ctr holds the saturating FILL counter: inputs CE and CLR, outputs FILL and the valid compare against A.
- The data array and read mux live in x_srl_chain. The output register also lives there.

## Test plan
- Reset load: WIDTH=8, DEPTH=16, INIT entry i = i. Assert RST_N=0 between edges. Required: Q tracks A (A=5 gives Q=0x05) immediately, and Q_VLD=0, FILL=0, QR=0.
- Shift and latency: 16 CE edges with D=0x10..0x1F. Required:
  - after the 3rd edge, FILL=3; Q_VLD=1 for A=2 and 0 for A=3;
  - after the 16th edge, A=0 gives Q=0x1F, A=15 gives Q=0x10, Q_LAST=0x10, FILL=16;
  - a 17th edge keeps FILL at 16.
- CE hold: CE=0 for 5 edges with D toggling. Required: data, FILL and Q_LAST unchanged.
- CLR versus CE:
  - CLR=1, CE=0 at FILL=10 gives FILL=0, data unchanged, Q_VLD=0 for all A;
  - CLR=1, CE=1 gives FILL=1 and data[0]=D.
- Output register: A=4, OCE=1. Required: QR equals the pre-edge Q one cycle later. OCE=0 holds QR while shifting continues.
- Mid-operation reset: pull RST_N low asynchronously during a CE burst, then release. Required: INIT is restored immediately and FILL=0. The first post-release CE edge writes data[0] and gives FILL=1.
